// File: rtl/circuit_sweep_ctrl_if.sv
// Control/result bundle between circuit_sweep_ctrl and its host
// (characterization/compare logic).
interface circuit_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned SIG_W = 16
);
  logic             start;
  logic             abort;
  logic             check_en;
  logic [SIG_W-1:0] golden_sig;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic [SIG_W-1:0] signature;
  logic [WIDTH-1:0] stuck0_mask;
  logic [WIDTH-1:0] stuck1_mask;
  logic             pass;

  modport master (
    output start, abort, check_en, golden_sig,
    input  busy, done, result_valid, signature, stuck0_mask, stuck1_mask, pass
  );

  modport slave (
    input  start, abort, check_en, golden_sig,
    output busy, done, result_valid, signature, stuck0_mask, stuck1_mask, pass
  );
endinterface

// File: rtl/circuit_sweep_ctrl.sv
// Exhaustive input sweeper for a WIDTH-bit combinational circuit: drives every
// vector, MISR-compresses the responses and tracks stuck-at-0/1 output masks.
module circuit_sweep_ctrl #(
  parameter int unsigned     WIDTH  = 5,
  parameter int unsigned     SETTLE = 1,
  parameter int unsigned     SIG_W  = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  circuit_sweep_ctrl_if.slave  ctl,
  output logic [WIDTH-1:0]     stim_o,
  input  logic [WIDTH-1:0]     resp_i
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [7:0] SETTLE_C = 8'(SETTLE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] stim_q,  stim_d;
  logic [7:0]       wcnt_q,  wcnt_d;
  logic [SIG_W-1:0] sig_q,   sig_d;
  logic [WIDTH-1:0] s0_q,    s0_d;
  logic [WIDTH-1:0] s1_q,    s1_d;
  logic             rv_q,    rv_d;
  logic             done_q,  done_d;
  logic [SIG_W-1:0] misr_next;

  // Shift left, fold the MSB back through POLY, then absorb the response.
  always_comb begin
    misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(resp_i);
  end

  always_comb begin
    state_d = state_q;
    stim_d  = stim_q;
    wcnt_d  = wcnt_q;
    sig_d   = sig_q;
    s0_d    = s0_q;
    s1_d    = s1_q;
    rv_d    = rv_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (ctl.start) begin
          state_d = S_RUN;
          stim_d  = '0;
          wcnt_d  = '0;
          sig_d   = SEED;
          s0_d    = '1;
          s1_d    = '1;
          rv_d    = 1'b0;
        end
      end
      S_RUN: begin
        if (ctl.abort) begin
          state_d = S_IDLE;
          stim_d  = '0;
          wcnt_d  = '0;
        end else if (wcnt_q < SETTLE_C) begin
          wcnt_d = wcnt_q + 8'd1;
        end else begin
          sig_d = misr_next;
          s0_d  = s0_q & ~resp_i;
          s1_d  = s1_q & resp_i;
          if (stim_q == '1) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            rv_d    = 1'b1;
          end else begin
            stim_d = stim_q + 1'b1;
            wcnt_d = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      stim_q  <= '0;
      wcnt_q  <= '0;
      sig_q   <= '0;
      s0_q    <= '0;
      s1_q    <= '0;
      rv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      stim_q  <= stim_d;
      wcnt_q  <= wcnt_d;
      sig_q   <= sig_d;
      s0_q    <= s0_d;
      s1_q    <= s1_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
    end
  end

  assign stim_o           = stim_q;
  assign ctl.busy         = (state_q == S_RUN);
  assign ctl.done         = done_q;
  assign ctl.result_valid = rv_q;
  assign ctl.signature    = sig_q;
  assign ctl.stuck0_mask  = s0_q;
  assign ctl.stuck1_mask  = s1_q;
  assign ctl.pass         = rv_q & (~ctl.check_en | (sig_q == ctl.golden_sig));

endmodule

// File: tb/tb_circuit_sweep_ctrl.sv
// Directed bench for circuit_sweep_ctrl: default instance (SETTLE=1) and a
// SETTLE=0 instance, each fed by a bench-side model of the swept circuit.
module tb_circuit_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] stim_a, resp_a;
  logic [4:0] stim_b, resp_b;
  int         mode = 0;   // 0: resp tied low, 1: decoder model
  int         n_checks = 0;
  int         n_pass   = 0;
  int         stim_bad = 0;
  logic       rv_e0;
  int         cyc;
  logic [15:0] sig_first;

  always #5 clk = ~clk;

  circuit_sweep_ctrl_if #(.WIDTH(5), .SIG_W(16)) ifa ();
  circuit_sweep_ctrl_if #(.WIDTH(5), .SIG_W(16)) ifb ();

  circuit_sweep_ctrl #(.WIDTH(5), .SETTLE(1), .SIG_W(16)) u_dut (
    .clk(clk), .rst(rst), .ctl(ifa.slave), .stim_o(stim_a), .resp_i(resp_a)
  );

  circuit_sweep_ctrl #(.WIDTH(5), .SETTLE(0), .SIG_W(16)) u_dut_s0 (
    .clk(clk), .rst(rst), .ctl(ifb.slave), .stim_o(stim_b), .resp_i(resp_b)
  );

  function automatic logic [4:0] model_resp(input logic [4:0] s);
    return {1'b0, 1'b1, s[2] & s[4], ~s[2], ~s[2] & ~s[4]};
  endfunction

  always_comb resp_a = (mode == 1) ? model_resp(stim_a) : 5'd0;
  always_comb resp_b = (stim_b == 5'd31) ? 5'd1 : 5'd0;

  function automatic logic [15:0] model_sig();
    logic [15:0] sg = 16'h0000;
    for (int s = 0; s < 32; s++)
      sg = {sg[14:0], 1'b0} ^ (sg[15] ? 16'h1021 : 16'h0000) ^ {11'b0, model_resp(5'(s))};
    return sg;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Start a sweep, count edges until done (bounded); optionally pulse start mid-run.
  task automatic run_sweep(input bit use_b, input int pulse_at, output int cycles);
    cycles   = 0;
    stim_bad = 0;
    @(negedge clk);
    if (use_b) ifb.start = 1'b1; else ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rv_e0 = use_b ? ifb.result_valid : ifa.result_valid;
    for (int k = 0; k < 200; k++) begin
      if (!use_b && stim_a !== 5'(k / 2)) stim_bad++;
      if (!use_b) ifa.start = (k == pulse_at);
      @(posedge clk); #1;
      cycles++;
      if (use_b ? ifb.done : ifa.done) break;
    end
    ifa.start = 1'b0;
  endtask

  initial begin
    ifa.start = 0; ifa.abort = 0; ifa.check_en = 0; ifa.golden_sig = '0;
    ifb.start = 0; ifb.abort = 0; ifb.check_en = 0; ifb.golden_sig = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_busy", ifa.busy, 0);
    check("rst_done", ifa.done, 0);
    check("rst_rv", ifa.result_valid, 0);
    check("rst_sig", ifa.signature, 0);
    check("rst_s0", ifa.stuck0_mask, 0);
    check("rst_s1", ifa.stuck1_mask, 0);
    check("rst_stim", stim_a, 0);
    check("rst_pass", ifa.pass, 0);

    // Reset mid-sweep at RUN cycle 10
    mode = 1;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    check("t1_busy_run", ifa.busy, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t1_busy", ifa.busy, 0);
    check("t1_stim", stim_a, 0);
    check("t1_rv", ifa.result_valid, 0);
    check("t1_done", ifa.done, 0);
    @(posedge clk); #1;
    check("t1_idle_stay", ifa.busy, 0);

    // Full sweep with the decoder model
    run_sweep(0, -1, cyc);
    check("t2_cycles", cyc, 64);
    check("t2_stim_seq", stim_bad, 0);
    check("t2_rv", ifa.result_valid, 1);
    check("t2_busy", ifa.busy, 0);
    check("t2_sig", ifa.signature, model_sig());
    check("t2_s0", ifa.stuck0_mask, 5'b10000);
    check("t2_s1", ifa.stuck1_mask, 5'b01000);
    check("t2_pass_noen", ifa.pass, 1);
    @(posedge clk); #1;
    check("t2_done_pulse", ifa.done, 0);
    check("t2_rv_hold", ifa.result_valid, 1);
    // abort in DONE has no effect
    ifa.abort = 1'b1;
    @(posedge clk); #1 ifa.abort = 1'b0;
    check("t2_abort_done_rv", ifa.result_valid, 1);
    check("t2_abort_done_busy", ifa.busy, 0);

    // resp tied low: zero signature and golden compare
    mode = 0;
    run_sweep(0, -1, cyc);
    check("t3_cycles", cyc, 64);
    check("t3_sig", ifa.signature, 16'h0000);
    check("t3_s0", ifa.stuck0_mask, 5'b11111);
    check("t3_s1", ifa.stuck1_mask, 5'b00000);
    ifa.check_en = 1'b1; ifa.golden_sig = 16'h0000; #1;
    check("t3_pass_match", ifa.pass, 1);
    ifa.golden_sig = 16'h0001; #1;
    check("t3_pass_miss", ifa.pass, 0);
    ifa.check_en = 1'b0; #1;
    check("t3_pass_dis", ifa.pass, 1);

    // SETTLE=0 instance, resp high only on the last vector
    run_sweep(1, -1, cyc);
    check("t4_cycles", cyc, 32);
    check("t4_sig", ifb.signature, 16'h0001);
    check("t4_s0", ifb.stuck0_mask, 5'b11110);
    check("t4_s1", ifb.stuck1_mask, 5'b00000);
    check("t4_rv", ifb.result_valid, 1);

    // Abort together with start at RUN cycle 20
    mode = 1;
    @(negedge clk) ifa.start = 1'b1;
    @(posedge clk); #1 ifa.start = 1'b0;
    repeat (20) @(posedge clk);
    #1 begin ifa.abort = 1'b1; ifa.start = 1'b1; end
    @(posedge clk); #1 begin ifa.abort = 1'b0; ifa.start = 1'b0; end
    check("t5_busy", ifa.busy, 0);
    check("t5_stim", stim_a, 0);
    check("t5_rv", ifa.result_valid, 0);
    check("t5_done", ifa.done, 0);
    @(posedge clk); #1;
    check("t5_done_late", ifa.done, 0);
    run_sweep(0, -1, cyc);
    check("t5_cycles", cyc, 64);
    check("t5_sig", ifa.signature, model_sig());

    // start during RUN ignored; start in DONE reruns identically
    run_sweep(0, 30, cyc);
    check("t6_cycles", cyc, 64);
    check("t6_stim_seq", stim_bad, 0);
    sig_first = ifa.signature;
    check("t6_sig", sig_first, model_sig());
    run_sweep(0, -1, cyc);
    check("t6_rv_drop", rv_e0, 0);
    check("t6_cycles2", cyc, 64);
    check("t6_sig_rerun", ifa.signature, sig_first);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
